// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Opcode/funct encodings, execute-stage state type and
//               immediate-extension helpers for the MIPS execute unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

   localparam logic [5:0] C_OP_RTYPE = 6'h00;
   localparam logic [5:0] C_OP_ADDI  = 6'h08;
   localparam logic [5:0] C_OP_ADDIU = 6'h09;
   localparam logic [5:0] C_OP_SLTI  = 6'h0A;
   localparam logic [5:0] C_OP_SLTIU = 6'h0B;
   localparam logic [5:0] C_OP_ANDI  = 6'h0C;
   localparam logic [5:0] C_OP_ORI   = 6'h0D;
   localparam logic [5:0] C_OP_XORI  = 6'h0E;
   localparam logic [5:0] C_OP_LUI   = 6'h0F;

   localparam logic [5:0] C_FN_SLL   = 6'h00;
   localparam logic [5:0] C_FN_SRL   = 6'h02;
   localparam logic [5:0] C_FN_SRA   = 6'h03;
   localparam logic [5:0] C_FN_SLLV  = 6'h04;
   localparam logic [5:0] C_FN_SRLV  = 6'h06;
   localparam logic [5:0] C_FN_SRAV  = 6'h07;
   localparam logic [5:0] C_FN_MFHI  = 6'h10;
   localparam logic [5:0] C_FN_MTHI  = 6'h11;
   localparam logic [5:0] C_FN_MFLO  = 6'h12;
   localparam logic [5:0] C_FN_MTLO  = 6'h13;
   localparam logic [5:0] C_FN_MULT  = 6'h18;
   localparam logic [5:0] C_FN_MULTU = 6'h19;
   localparam logic [5:0] C_FN_DIV   = 6'h1A;
   localparam logic [5:0] C_FN_DIVU  = 6'h1B;
   localparam logic [5:0] C_FN_ADD   = 6'h20;
   localparam logic [5:0] C_FN_ADDU  = 6'h21;
   localparam logic [5:0] C_FN_SUB   = 6'h22;
   localparam logic [5:0] C_FN_SUBU  = 6'h23;
   localparam logic [5:0] C_FN_AND   = 6'h24;
   localparam logic [5:0] C_FN_OR    = 6'h25;
   localparam logic [5:0] C_FN_XOR   = 6'h26;
   localparam logic [5:0] C_FN_NOR   = 6'h27;
   localparam logic [5:0] C_FN_SLT   = 6'h2A;
   localparam logic [5:0] C_FN_SLTU  = 6'h2B;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXEC   = 2'd1,
      ST_MULDIV = 2'd2,
      ST_FIX    = 2'd3
   } state_t;

   function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

   function automatic logic [31:0] zero_ext16(input logic [15:0] imm);
      return {16'h0000, imm};
   endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : Unsigned 32x32 shift-add multiplier / restoring divider,
//               one bit per cycle. o_done marks the cycle of the last step.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
   parameter int MD_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_start,
   input  logic        i_div,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic        o_done,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo
);
   import mips_pkg::*;

   localparam int C_CW = $clog2(MD_CYCLES);

   logic            r_busy;
   logic            r_div;
   logic [C_CW-1:0] r_cnt;
   logic [31:0]     r_opb;
   logic [63:0]     r_acc;

   logic [32:0]     w_add;
   logic [64:0]     w_shl;
   logic [32:0]     w_trial;

   // Multiply: {hi,lo} holds partial product over the shifting multiplier.
   // Divide:   {hi,lo} holds remainder over dividend/quotient bits.
   assign w_add   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
   assign w_shl   = {r_acc, 1'b0};
   assign w_trial = w_shl[64:32] - {1'b0, r_opb};

   assign o_done = r_busy && (r_cnt == C_CW'(MD_CYCLES - 1));
   assign o_hi   = r_acc[63:32];
   assign o_lo   = r_acc[31:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy <= 1'b0;
         r_div  <= 1'b0;
         r_cnt  <= '0;
         r_opb  <= '0;
         r_acc  <= '0;
      end else if (i_start) begin
         r_busy <= 1'b1;
         r_div  <= i_div;
         r_cnt  <= '0;
         r_opb  <= i_b;
         r_acc  <= {32'h0, i_a};
      end else if (r_busy) begin
         r_cnt <= r_cnt + 1'b1;
         if (o_done) r_busy <= 1'b0;
         if (!r_div)
            r_acc <= {w_add, r_acc[31:1]};
         else if (!w_trial[32])
            r_acc <= {w_trial[31:0], w_shl[31:1], 1'b1};
         else
            r_acc <= {w_shl[63:32], w_shl[31:1], 1'b0};
      end
   end

endmodule
`default_nettype wire

// File: rtl/mips_execute_unit.sv
`default_nettype none
// ============================================================================
// Module      : mips_execute_unit
// Description : Multicycle MIPS execute stage: decode, ALU, HI/LO and the
//               control FSM around the iterative multiply/divide engine.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_execute_unit #(
   parameter int MD_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] instr,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        ready,
   output logic        wb_valid,
   output logic        wb_en,
   output logic        reg_dst,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic        ovf,
   output logic        illegal
);
   import mips_pkg::*;

   state_t      r_state;
   logic        r_ready, r_wb_valid, r_wb_en, r_reg_dst, r_ovf, r_illegal;
   logic [4:0]  r_wb_addr;
   logic [31:0] r_wb_data;
   logic [31:0] r_instr, r_a, r_b, r_hi, r_lo;

   logic        w_accept, w_in_md, w_in_signed, w_md_start, w_md_done;
   logic [31:0] w_mag_a, w_mag_b, w_md_hi, w_md_lo;

   // Multiply/divide is recognised on the raw instruction so the engine
   // loads on the accept edge and its 32 steps land on k+1..k+32.
   assign w_accept    = in_valid && r_ready;
   assign w_in_md     = (instr[31:26] == C_OP_RTYPE) && (instr[5:2] == 4'b0110);
   assign w_in_signed = ~instr[0];
   assign w_mag_a     = (w_in_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
   assign w_mag_b     = (w_in_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;
   assign w_md_start  = w_accept && w_in_md;

   muldiv_iter #(.MD_CYCLES(MD_CYCLES)) u_muldiv (
      .clk     (clk),
      .reset   (reset),
      .i_start (w_md_start),
      .i_div   (instr[1]),
      .i_a     (w_mag_a),
      .i_b     (w_mag_b),
      .o_done  (w_md_done),
      .o_hi    (w_md_hi),
      .o_lo    (w_md_lo)
   );

   logic [5:0]  w_op, w_fn;
   logic [4:0]  w_shamt;
   logic [31:0] w_simm, w_zimm, w_sum, w_diff, w_sum_i;
   logic [31:0] w_res;
   logic        w_wen, w_ovf, w_ill, w_wr_hi, w_wr_lo, w_rtype;

   assign w_op    = r_instr[31:26];
   assign w_fn    = r_instr[5:0];
   assign w_shamt = r_instr[10:6];
   assign w_simm  = sign_ext16(r_instr[15:0]);
   assign w_zimm  = zero_ext16(r_instr[15:0]);
   assign w_sum   = r_a + r_b;
   assign w_diff  = r_a - r_b;
   assign w_sum_i = r_a + w_simm;
   assign w_rtype = (w_op == C_OP_RTYPE);

   always_comb begin
      w_res   = '0;
      w_wen   = 1'b1;
      w_ovf   = 1'b0;
      w_ill   = 1'b0;
      w_wr_hi = 1'b0;
      w_wr_lo = 1'b0;
      case (w_op)
         C_OP_RTYPE: begin
            case (w_fn)
               C_FN_SLL:  w_res = r_b << w_shamt;
               C_FN_SRL:  w_res = r_b >> w_shamt;
               C_FN_SRA:  w_res = $signed(r_b) >>> w_shamt;
               C_FN_SLLV: w_res = r_b << r_a[4:0];
               C_FN_SRLV: w_res = r_b >> r_a[4:0];
               C_FN_SRAV: w_res = $signed(r_b) >>> r_a[4:0];
               C_FN_MFHI: w_res = r_hi;
               C_FN_MFLO: w_res = r_lo;
               C_FN_MTHI: begin w_wen = 1'b0; w_wr_hi = 1'b1; end
               C_FN_MTLO: begin w_wen = 1'b0; w_wr_lo = 1'b1; end
               C_FN_ADD: begin
                  w_res = w_sum;
                  w_ovf = (r_a[31] == r_b[31]) && (w_sum[31] != r_a[31]);
               end
               C_FN_ADDU: w_res = w_sum;
               C_FN_SUB: begin
                  w_res = w_diff;
                  w_ovf = (r_a[31] != r_b[31]) && (w_diff[31] != r_a[31]);
               end
               C_FN_SUBU: w_res = w_diff;
               C_FN_AND:  w_res = r_a & r_b;
               C_FN_OR:   w_res = r_a | r_b;
               C_FN_XOR:  w_res = r_a ^ r_b;
               C_FN_NOR:  w_res = ~(r_a | r_b);
               C_FN_SLT:  w_res = {31'b0, $signed(r_a) < $signed(r_b)};
               C_FN_SLTU: w_res = {31'b0, r_a < r_b};
               default:   begin w_wen = 1'b0; w_ill = 1'b1; end
            endcase
         end
         C_OP_ADDI: begin
            w_res = w_sum_i;
            w_ovf = (r_a[31] == w_simm[31]) && (w_sum_i[31] != r_a[31]);
         end
         C_OP_ADDIU: w_res = w_sum_i;
         C_OP_SLTI:  w_res = {31'b0, $signed(r_a) < $signed(w_simm)};
         C_OP_SLTIU: w_res = {31'b0, r_a < w_simm};
         C_OP_ANDI:  w_res = r_a & w_zimm;
         C_OP_ORI:   w_res = r_a | w_zimm;
         C_OP_XORI:  w_res = r_a ^ w_zimm;
         C_OP_LUI:   w_res = {r_instr[15:0], 16'h0000};
         default:    begin w_wen = 1'b0; w_ill = 1'b1; end
      endcase
   end

   // Sign correction of the magnitude result; divide-by-zero is pinned
   // explicitly so the signed case does not inherit a negated |a|.
   logic        w_md_div, w_neg_q, w_neg_r;
   logic [63:0] w_prod;
   logic [31:0] w_fix_hi, w_fix_lo;

   assign w_md_div = r_instr[1];
   assign w_neg_q  = ~r_instr[0] && (r_a[31] ^ r_b[31]);
   assign w_neg_r  = ~r_instr[0] && r_a[31];
   assign w_prod   = {w_md_hi, w_md_lo};

   always_comb begin
      w_fix_hi = w_md_hi;
      w_fix_lo = w_md_lo;
      if (!w_md_div) begin
         {w_fix_hi, w_fix_lo} = w_neg_q ? (~w_prod + 64'd1) : w_prod;
      end else if (r_b == 32'h0) begin
         w_fix_hi = r_a;
         w_fix_lo = 32'hFFFF_FFFF;
      end else begin
         w_fix_lo = w_neg_q ? (~w_md_lo + 32'd1) : w_md_lo;
         w_fix_hi = w_neg_r ? (~w_md_hi + 32'd1) : w_md_hi;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_ready    <= 1'b1;
         r_wb_valid <= 1'b0;
         r_wb_en    <= 1'b0;
         r_reg_dst  <= 1'b0;
         r_wb_addr  <= '0;
         r_wb_data  <= '0;
         r_ovf      <= 1'b0;
         r_illegal  <= 1'b0;
         r_instr    <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
      end else begin
         r_wb_valid <= 1'b0;
         r_wb_en    <= 1'b0;
         r_reg_dst  <= 1'b0;
         r_wb_addr  <= '0;
         r_wb_data  <= '0;
         r_ovf      <= 1'b0;
         r_illegal  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_instr <= instr;
                  r_a     <= op_a;
                  r_b     <= op_b;
                  r_ready <= 1'b0;
                  r_state <= w_in_md ? ST_MULDIV : ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_wb_valid <= 1'b1;
               r_wb_en    <= w_wen;
               r_wb_data  <= w_res;
               r_ovf      <= w_ovf;
               r_illegal  <= w_ill;
               r_reg_dst  <= w_rtype;
               r_wb_addr  <= w_rtype ? r_instr[15:11] : r_instr[20:16];
               if (w_wr_hi) r_hi <= r_a;
               if (w_wr_lo) r_lo <= r_a;
               r_ready    <= 1'b1;
               r_state    <= ST_IDLE;
            end
            ST_MULDIV: begin
               if (w_md_done) r_state <= ST_FIX;
            end
            ST_FIX: begin
               r_hi       <= w_fix_hi;
               r_lo       <= w_fix_lo;
               r_wb_valid <= 1'b1;
               r_reg_dst  <= 1'b1;
               r_wb_addr  <= r_instr[15:11];
               r_ready    <= 1'b1;
               r_state    <= ST_IDLE;
            end
            default: begin
               r_ready <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ready    = r_ready;
   assign wb_valid = r_wb_valid;
   assign wb_en    = r_wb_en;
   assign reg_dst  = r_reg_dst;
   assign wb_addr  = r_wb_addr;
   assign wb_data  = r_wb_data;
   assign ovf      = r_ovf;
   assign illegal  = r_illegal;

endmodule
`default_nettype wire
